// File: rtl/text_buffer_pkg.sv
// Shared constants and sizing helpers for the character screen buffer.
// Control codes, FSM state encodings and geometry functions live here.
package text_buffer_pkg;

    function automatic int log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    function automatic int cols_of(input int width, input int cell_w);
        return width / cell_w;
    endfunction

    function automatic int rows_of(input int height, input int cell_h);
        return height / cell_h;
    endfunction

    function automatic int cells_of(input int width, input int height,
                                    input int cell_w, input int cell_h);
        return cols_of(width, cell_w) * rows_of(height, cell_h);
    endfunction

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CLR_LINE = 2'd1;
    localparam logic [1:0] ST_CLR_ALL  = 2'd2;

endpackage

// File: rtl/text_buffer_ram.sv
// Simple dual-port cell RAM: one synchronous write port, one synchronous
// read-first read port.
module text_ram #(
    parameter int DEPTH  = 6144,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    // NOTE: contents are deliberately not reset so the array maps onto block
    // RAM; the power-up clear sweep initialises every cell instead.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: non-blocking assignments make the read see the pre-write value
    // of a cell written in the same cycle (read-first).
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/text_buffer.sv
// Character screen buffer: host character stream in, cursor/scroll state,
// and a 1-cycle pixel-to-character lookup for the font renderer.
module text_buffer
    import text_buffer_pkg::*;
#(
    parameter int width      = 1024,
    parameter int height     = 768,
    parameter int text_th_w  = 8,
    parameter int text_th_h  = 16,
    parameter int char_width = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          wr_valid,
    input  logic [char_width-1:0]                         wr_char,
    output logic                                          wr_ready,
    input  logic [log2(width)-1:0]                        x_pixel,
    input  logic [log2(height)-1:0]                       y_pixel,
    output logic [char_width-1:0]                         cur_char,
    output logic [log2(cols_of(width, text_th_w))-1:0]    cursor_col,
    output logic [log2(rows_of(height, text_th_h))-1:0]   cursor_row
);

    localparam int COLS   = cols_of(width, text_th_w);
    localparam int ROWS   = rows_of(height, text_th_h);
    localparam int CELLS  = cells_of(width, height, text_th_w, text_th_h);
    localparam int COL_W  = log2(COLS);
    localparam int ROW_W  = log2(ROWS);
    localparam int ADDR_W = log2(CELLS);
    localparam int SH_W   = log2(text_th_w);
    localparam int SH_H   = log2(text_th_h);

    localparam logic [char_width-1:0] C_LF    = char_width'(CH_LF);
    localparam logic [char_width-1:0] C_CR    = char_width'(CH_CR);
    localparam logic [char_width-1:0] C_BS    = char_width'(CH_BS);
    localparam logic [char_width-1:0] C_FF    = char_width'(CH_FF);
    localparam logic [char_width-1:0] C_BLANK = char_width'(CH_BLANK);

    // Logical-to-physical row with an explicit subtract; ROWS need not be 2^n.
    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] l,
                                                  input logic [ROW_W-1:0] t);
        logic [ROW_W:0] s;
        s = {1'b0, l} + {1'b0, t};
        if (s >= (ROW_W+1)'(ROWS)) s = s - (ROW_W+1)'(ROWS);
        return s[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] r,
                                                    input logic [COL_W-1:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    logic [1:0]            r_state;
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [ROW_W-1:0]      r_top;
    logic [ROW_W-1:0]      r_clr_row;
    logic [ADDR_W-1:0]     r_clr_ptr;
    logic                  r_rd_vld;
    logic                  r_rd_oob;

    logic                  w_accept;
    logic                  w_is_lf, w_is_cr, w_is_bs, w_is_ff, w_is_print;
    logic                  w_row_adv;
    logic [ROW_W-1:0]      w_cur_phys;
    logic [ROW_W-1:0]      w_top_next;
    logic                  w_wr_en;
    logic [ADDR_W-1:0]     w_wr_addr;
    logic [char_width-1:0] w_wr_data;
    logic                  w_rd_oob;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [char_width-1:0] w_ram_q;

    assign wr_ready   = (r_state == ST_IDLE);
    assign w_accept   = wr_valid && wr_ready;
    assign w_is_lf    = (wr_char == C_LF);
    assign w_is_cr    = (wr_char == C_CR);
    assign w_is_bs    = (wr_char == C_BS);
    assign w_is_ff    = (wr_char == C_FF);
    assign w_is_print = !(w_is_lf || w_is_cr || w_is_bs || w_is_ff);
    assign w_row_adv  = w_accept && (w_is_lf || (w_is_print && r_col == COL_W'(COLS-1)));
    assign w_cur_phys = phys_row(r_row, r_top);
    assign w_top_next = phys_row(ROW_W'(1), r_top);

    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = cell_addr(w_cur_phys, r_col);
        w_wr_data = wr_char;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_bs) begin
                    w_wr_en   = (r_col != '0);
                    w_wr_addr = cell_addr(w_cur_phys, r_col - COL_W'(1));
                    w_wr_data = C_BLANK;
                end else if (w_accept && w_is_print) begin
                    w_wr_en = 1'b1;
                end
            end
            ST_CLR_LINE: begin
                w_wr_en   = 1'b1;
                w_wr_addr = cell_addr(r_clr_row, r_clr_ptr[COL_W-1:0]);
                w_wr_data = C_BLANK;
            end
            ST_CLR_ALL: begin
                w_wr_en   = 1'b1;
                w_wr_addr = r_clr_ptr;
                w_wr_data = C_BLANK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_CLR_ALL;
            r_col     <= '0;
            r_row     <= '0;
            r_top     <= '0;
            r_clr_row <= '0;
            r_clr_ptr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_is_ff) begin
                            r_col     <= '0;
                            r_row     <= '0;
                            r_top     <= '0;
                            r_clr_ptr <= '0;
                            r_state   <= ST_CLR_ALL;
                        end else if (w_is_lf || w_is_cr) begin
                            r_col <= '0;
                        end else if (w_is_bs) begin
                            if (r_col != '0) r_col <= r_col - COL_W'(1);
                        end else if (r_col == COL_W'(COLS-1)) begin
                            r_col <= '0;
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        // Scroll: old top row becomes the new bottom and is blanked.
                        if (w_row_adv) begin
                            if (r_row < ROW_W'(ROWS-1)) begin
                                r_row <= r_row + ROW_W'(1);
                            end else begin
                                r_top     <= w_top_next;
                                r_clr_row <= r_top;
                                r_clr_ptr <= '0;
                                r_state   <= ST_CLR_LINE;
                            end
                        end
                    end
                end
                ST_CLR_LINE: begin
                    if (r_clr_ptr == ADDR_W'(COLS-1)) r_state <= ST_IDLE;
                    else r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                end
                ST_CLR_ALL: begin
                    if (r_clr_ptr == ADDR_W'(CELLS-1)) r_state <= ST_IDLE;
                    else r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_rd_oob  = (32'(x_pixel) >= 32'(width)) || (32'(y_pixel) >= 32'(height));
    assign w_rd_addr = w_rd_oob ? '0 :
                       cell_addr(phys_row(ROW_W'(y_pixel >> SH_H), r_top),
                                 COL_W'(x_pixel >> SH_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld <= 1'b0;
            r_rd_oob <= 1'b0;
        end else begin
            r_rd_vld <= 1'b1;
            r_rd_oob <= w_rd_oob;
        end
    end

    text_ram #(
        .DEPTH (CELLS),
        .DATA_W(char_width),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(w_wr_addr),
        .i_wr_data(w_wr_data),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_ram_q)
    );

    assign cur_char   = !r_rd_vld ? '0 : (r_rd_oob ? C_BLANK : w_ram_q);
    assign cursor_col = r_col;
    assign cursor_row = r_row;

endmodule

// File: tb/tb_text_buffer.sv
// Directed bench for text_buffer: table of write/read vectors plus
// hand-written clear, scroll and reset-mid-clear sequences.
module tb_text_buffer;

    localparam int COLS  = 128;
    localparam int ROWS  = 48;
    localparam int CELLS = 6144;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_char = 8'h00;
    logic       wr_ready;
    logic [9:0] x_pixel = 10'd0;
    logic [9:0] y_pixel = 10'd0;
    logic [7:0] cur_char;
    logic [6:0] cursor_col;
    logic [5:0] cursor_row;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         do_wr;
        logic [7:0] ch;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] exp_char;
        logic [6:0] exp_col;
        logic [5:0] exp_row;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    text_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .wr_valid  (wr_valid),
        .wr_char   (wr_char),
        .wr_ready  (wr_ready),
        .x_pixel   (x_pixel),
        .y_pixel   (y_pixel),
        .cur_char  (cur_char),
        .cursor_col(cursor_col),
        .cursor_row(cursor_row)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [7:0] ch);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_char  = ch;
        while (!wr_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) check("send_ready_timeout", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!wr_ready && cnt < 20000) begin
            @(negedge clk);
            cnt++;
        end
    endtask

    task automatic read_cell(input logic [9:0] x, input logic [9:0] y, output logic [7:0] q);
        x_pixel = x;
        y_pixel = y;
        @(negedge clk);
        q = cur_char;
    endtask

    task automatic sweep(input int r0, input int r1, input logic [7:0] exp, output int bad);
        logic [7:0] q;
        bad = 0;
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < COLS; c++) begin
                read_cell(10'(c * 8 + (c % 8)), 10'(r * 16 + (r % 16)), q);
                if (q !== exp) bad++;
            end
        end
    endtask

    initial begin
        int n;
        int bad;
        logic [7:0] q;

        //            wr    ch     x        y        char   col    row
        vecs[0]  = '{1'b1, 8'h41, 10'd3,    10'd10,  8'h41, 7'd1, 6'd0};
        vecs[1]  = '{1'b0, 8'h00, 10'd8,    10'd0,   8'h20, 7'd1, 6'd0};
        vecs[2]  = '{1'b1, 8'h0D, 10'd0,    10'd0,   8'h41, 7'd0, 6'd0};
        vecs[3]  = '{1'b1, 8'h43, 10'd0,    10'd15,  8'h43, 7'd1, 6'd0};
        vecs[4]  = '{1'b1, 8'h08, 10'd7,    10'd0,   8'h20, 7'd0, 6'd0};
        vecs[5]  = '{1'b1, 8'h44, 10'd0,    10'd0,   8'h44, 7'd1, 6'd0};
        vecs[6]  = '{1'b1, 8'h0D, 10'd0,    10'd0,   8'h44, 7'd0, 6'd0};
        vecs[7]  = '{1'b1, 8'h08, 10'd0,    10'd0,   8'h44, 7'd0, 6'd0};
        vecs[8]  = '{1'b1, 8'h0A, 10'd0,    10'd16,  8'h20, 7'd0, 6'd1};
        vecs[9]  = '{1'b1, 8'h45, 10'd0,    10'd31,  8'h45, 7'd1, 6'd1};
        vecs[10] = '{1'b0, 8'h00, 10'd0,    10'd784, 8'h20, 7'd1, 6'd1};
        vecs[11] = '{1'b0, 8'h00, 10'd1023, 10'd767, 8'h20, 7'd1, 6'd1};

        repeat (3) @(negedge clk);
        check("rst_ready", wr_ready, 0);
        check("rst_cur_char", cur_char, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);

        reset = 1'b0;
        wait_ready(n);
        check("init_clear_cycles", n, CELLS);
        sweep(0, ROWS - 1, 8'h20, bad);
        check("init_all_blank", bad, 0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) send(vecs[i].ch);
            read_cell(vecs[i].x, vecs[i].y, q);
            check($sformatf("vec%0d_char", i), q, vecs[i].exp_char);
            check($sformatf("vec%0d_col", i), cursor_col, vecs[i].exp_col);
            check($sformatf("vec%0d_row", i), cursor_row, vecs[i].exp_row);
        end

        // Form feed mid-screen with wr_valid held through the clear.
        send(8'h0C);
        wr_valid = 1'b1;
        wr_char  = 8'h58;
        check("ff_col", cursor_col, 0);
        check("ff_row", cursor_row, 0);
        wait_ready(n);
        wr_valid = 1'b0;
        check("ff_clear_cycles", n, CELLS);
        sweep(0, ROWS - 1, 8'h20, bad);
        check("ff_all_blank", bad, 0);
        check("ff_col_after", cursor_col, 0);
        check("ff_row_after", cursor_row, 0);

        // A full line wraps the cursor to the next row.
        for (int i = 0; i < COLS; i++) send(8'(8'h30 + i));
        check("line_col", cursor_col, 0);
        check("line_row", cursor_row, 1);
        read_cell(10'd1023, 10'd0, q);
        check("line_last_char", q, 8'hAF);
        read_cell(10'd0, 10'd0, q);
        check("line_first_char", q, 8'h30);

        // Scroll by LF from the bottom row.
        send(8'h5A);
        for (int i = 0; i < ROWS - 2; i++) send(8'h0A);
        check("pre_scroll_row", cursor_row, ROWS - 1);
        check("pre_scroll_ready", wr_ready, 1);
        send(8'h0A);
        wait_ready(n);
        check("scroll_clear_cycles", n, COLS);
        check("scroll_col", cursor_col, 0);
        check("scroll_row", cursor_row, ROWS - 1);
        read_cell(10'd0, 10'd0, q);
        check("scroll_top_shifted", q, 8'h5A);
        sweep(ROWS - 1, ROWS - 1, 8'h20, bad);
        check("scroll_bottom_blank", bad, 0);

        // Printable character in the last cell triggers a scroll.
        for (int i = 0; i < COLS; i++) send(8'(8'h30 + i));
        wait_ready(n);
        check("lastcell_clear_cycles", n, COLS);
        check("lastcell_col", cursor_col, 0);
        check("lastcell_row", cursor_row, ROWS - 1);
        read_cell(10'd1023, 10'd736, q);
        check("lastcell_char_row46", q, 8'hAF);
        read_cell(10'd0, 10'd736, q);
        check("lastcell_first_row46", q, 8'h30);
        read_cell(10'd0, 10'd0, q);
        check("lastcell_top_scrolled_off", q, 8'h20);
        sweep(ROWS - 1, ROWS - 1, 8'h20, bad);
        check("lastcell_bottom_blank", bad, 0);

        // Reset in the middle of a full clear restarts the sweep.
        send(8'h0C);
        repeat (1000) @(negedge clk);
        check("midclr_ready", wr_ready, 0);
        reset = 1'b1;
        #1;
        check("midclr_rst_cur_char", cur_char, 0);
        check("midclr_rst_ready", wr_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_ready(n);
        check("midclr_clear_cycles", n, CELLS);
        check("midclr_col", cursor_col, 0);
        check("midclr_row", cursor_row, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_buffer.md
Name: text_buffer

Overview:
- Character screen buffer directly upstream of the font renderer: it accepts a character stream from the host, maintains cursor/scroll state, and stores characters in a COLS x ROWS cell RAM.
- It also serves the renderer's pixel-driven lookups, mapping (x_pixel, y_pixel) to cur_char with 1-cycle latency.
- Scrolling uses a circular top-row offset. No data is copied.

Parameters:
- width, 1024, screen width in pixels
- height, 768, screen height in pixels
- text_th_w, 8, glyph cell width in pixels (power of 2)
- text_th_h, 16, glyph cell height in pixels (power of 2)
- char_width, 8, character code width in bits
- Derived: COLS = width/text_th_w (128); ROWS = height/text_th_h (48); CELLS = COLS*ROWS (6144)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- wr_valid  in  1  host presents wr_char
- wr_char  in  char_width  character code or control code
- wr_ready  out  1  buffer accepts wr_char this cycle
- x_pixel  in  log2(width)  renderer pixel column
- y_pixel  in  log2(height)  renderer pixel row
- cur_char  out  char_width  character at the cell containing (x_pixel, y_pixel), 1 cycle later
- cursor_col  out  log2(COLS)  current cursor column
- cursor_row  out  log2(ROWS)  current cursor logical row (0 = top of screen)

Behaviour:
- Reset (async, active-high): cursor_col=0, cursor_row=0, top_row=0, cur_char=0, wr_ready=0, FSM=CLR_ALL with clr_ptr=0.
- FSM states and transitions:
  - IDLE: wr_ready=1. A write is accepted when wr_valid && wr_ready.
  - CLR_LINE: wr_ready=0. Writes 0x20 to COLS consecutive cells of one physical row, one per cycle, then returns to IDLE. Lasts exactly COLS cycles.
  - CLR_ALL: wr_ready=0. Writes 0x20 to all CELLS cells, one per cycle, then returns to IDLE. Lasts exactly CELLS cycles.
- Physical row = (logical row + top_row) mod ROWS. Modular add is explicit: subtract ROWS on overflow. No reliance on power-of-2 ROWS.
- Accepted codes in IDLE:
  - 0x0A (LF): col=0. If row<ROWS-1 then row++; else scroll.
  - 0x0D (CR): col=0, row unchanged.
  - 0x08 (BS): if col>0, col-- and write 0x20 at the new position. At col=0: no-op, no reverse wrap.
  - 0x0C (FF): cursor=(0,0), top_row=0, enter CLR_ALL.
  - Any other code: write it at (row, col), then col++.
    - If col was COLS-1: col=0, and the row advances as for LF, including scroll.
- Scroll:
  - top_row = (top_row+1) mod ROWS; cursor_row stays ROWS-1.
  - Enter CLR_LINE on the physical row that is now logical row ROWS-1, i.e. the old top row.
- Write-at-last-cell: the character is written to the RAM in the same cycle as the scroll decision. It lands in the old bottom row, which becomes logical ROWS-2 after the scroll.
- wr_valid while wr_ready=0 is ignored (not queued). The host must hold wr_valid until it sees ready.
- Read path:
  - Cell = (y_pixel>>log2(text_th_h), x_pixel>>log2(text_th_w)) mapped through top_row.
  - Registered RAM read; cur_char is valid 1 cycle after the pixel coordinates.
  - Reads continue during CLR_* states and return whatever the RAM holds (stale or 0x20).
- Read/write to the same cell in the same cycle returns old data (read-first).
- Coordinates outside the screen (x ≥ width or y ≥ height): cur_char=0x20.
- Reset mid-clear: the clear restarts from cell 0. Cursor and offset return to 0.

Decomposition:
- Shared package/header (alongside const_funcs.h):
  - log2 function
  - control codes LF=0x0A, CR=0x0D, BS=0x08, FF=0x0C, BLANK=0x20
  - FSM state encoding IDLE/CLR_LINE/CLR_ALL
  - derived COLS/ROWS/CELLS functions
- Sub-module text_ram:
  - simple dual-port, CELLS x char_width
  - one synchronous write port, one synchronous read port (read-first), no reset on contents
  - address = phys_row*COLS + col; with power-of-2 COLS this is {phys_row, col}

Test Plan:
- Reset release -> wr_ready low for exactly 6144 cycles, then high; every cell reads cur_char=0x20.
- After init, write 0x41 -> cursor (0,1); x_pixel=3, y_pixel=10 gives cur_char=0x41 next cycle; x_pixel=8 gives 0x20.
- Write 128 chars 0x30..0xAF -> cursor (1,0); x=1023, y=0 reads 0xAF.
- Write 0x41 at row 0, then 48 LF -> wr_ready low for 128 cycles; cursor (47,0); row 47 reads all 0x20; the 0x41 is gone (scrolled off); top_row=1.
- BS at col 0 -> cursor unchanged, no RAM write. Then 'B', BS -> cursor (r,0), cell reads 0x20.
- FF mid-screen with wr_valid held high -> cursor (0,0); 6144 cycles of ready=0 with wr_valid ignored; all cells 0x20. Assert reset mid-clear -> clear restarts, ready low for a full 6144 cycles.
